// File: rtl/seq_subtractor.sv
// seq_subtractor: multi-cycle subtractor D = a - b - bin, W bits per clock.
// Operands are consumed LSB slice first; a registered borrow links slices.
// Valid/ready handshake on both the operand and result sides.
// Optional feature macro: SUB_OVF_EN adds the signed-overflow output ovf.
module seq_subtractor #(
   parameter int N = 32,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] d,
   output logic         bout,
   output logic         zero
`ifdef SUB_OVF_EN
   ,
   output logic         ovf
`endif
);

   localparam int K  = N / W;
   localparam int CW = (K > 1) ? $clog2(K) : 1;
   localparam logic [CW-1:0] LAST = CW'(K - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nx;

   logic          accept;
   logic          busy;
   logic          last;

   logic [N-1:0]  a_sh;
   logic [N-1:0]  b_sh;
   logic          borrow;
   logic [CW-1:0] cnt;

   logic [W:0]    sum;
   logic [W-1:0]  s;
   logic          c;
   logic [N-1:0]  d_nx;

   // State register; reset drops any operation in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and handshake outputs; no same-cycle DONE->accept turnaround.
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      busy      = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept   = 1'b1;
               state_nx = BUSY;
            end
         end
         BUSY: begin
            busy = 1'b1;
            if (cnt == LAST) begin
               last     = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // One slice of a + ~b + !borrow; carry-out of the slice is the inverted borrow.
   always_comb begin
      sum  = {1'b0, a_sh[W-1:0]} + {1'b0, ~b_sh[W-1:0]} + {{W{1'b0}}, ~borrow};
      s    = sum[W-1:0];
      c    = sum[W];
      d_nx = d;
      for (int k = 0; k < K; k++) begin
         if (cnt == CW'(k)) begin
            d_nx[k*W +: W] = s;
         end
      end
   end

   // Slice counter and inter-slice borrow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt    <= '0;
         borrow <= 1'b0;
      end else if (accept) begin
         cnt    <= '0;
         borrow <= bin;
      end else if (busy) begin
         cnt    <= cnt + CW'(1);
         borrow <= ~c;
      end
   end

   // Operand shift registers: the next slice is always at the LSB end.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_sh <= a;
         b_sh <= b;
      end else if (busy) begin
         a_sh <= a_sh >> W;
         b_sh <= b_sh >> W;
      end
   end

   // Result registers; flags are finalised on the last slice and then held.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         d    <= '0;
         bout <= 1'b0;
         zero <= 1'b0;
      end else if (busy) begin
         d <= d_nx;
         if (last) begin
            bout <= ~c;
            zero <= (d_nx == '0);
         end
      end
   end

`ifdef SUB_OVF_EN
   logic a_sgn;
   logic b_sgn;

   // Operand sign bits captured at accept, since the shift registers lose them.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_sgn <= a[N-1];
         b_sgn <= b[N-1];
      end
   end

   // Signed overflow: operand signs differ and result sign differs from a.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (last) begin
         ovf <= (a_sgn != b_sgn) && (d_nx[N-1] != a_sgn);
      end
   end
`endif

endmodule

// File: tb/tb_seq_subtractor.sv
// Directed-vector bench for seq_subtractor (N=32, W=8).
// ovf is connected and checked only when SUB_OVF_EN is defined.
module tb_seq_subtractor;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        bin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] d;
   logic        bout;
   logic        zero;
   logic        ovf;

   int checks;
   int errors;

   seq_subtractor #(.N(32), .W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .bout      (bout),
      .zero      (zero)
`ifdef SUB_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

`ifndef SUB_OVF_EN
   assign ovf = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one operation, lets it be accepted, then waits (bounded) for out_valid.
   task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic bi,
                         output int cyc);
      a        = av;
      b        = bv;
      bin      = bi;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a        = 32'hDEADBEEF;
      b        = 32'h0BADF00D;
      bin      = 1'b1;
      cyc      = 0;
      while (!out_valid && cyc < 20) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_d got %h want 00000000", d); end
      checks++; if (bout !== 1'b0 || zero !== 1'b0) begin errors++; $display("FAIL reset_flags got bout=%b zero=%b want 0 0", bout, zero); end
`ifdef SUB_OVF_EN
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
      rst_n = 1'b1;
      tick();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
   endtask

   task automatic test_basic();
      int cyc;
      run_op(32'd5, 32'd3, 1'b0, cyc);
      checks++; if (cyc !== 4) begin errors++; $display("FAIL basic_latency got %0d want 4", cyc); end
      checks++; if (d !== 32'd2) begin errors++; $display("FAIL basic_d got %h want 00000002", d); end
      checks++; if (bout !== 1'b0 || zero !== 1'b0) begin errors++; $display("FAIL basic_flags got bout=%b zero=%b want 0 0", bout, zero); end
`ifdef SUB_OVF_EN
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", ovf); end
`endif
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_done got %b want 0", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_handshake got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
   endtask

   task automatic test_borrow_ripple();
      int cyc;
      run_op(32'd0, 32'd1, 1'b0, cyc);
      checks++; if (cyc !== 4) begin errors++; $display("FAIL ripple_latency got %0d want 4", cyc); end
      checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL ripple_d got %h want ffffffff", d); end
      checks++; if (bout !== 1'b1 || zero !== 1'b0) begin errors++; $display("FAIL ripple_flags got bout=%b zero=%b want 1 0", bout, zero); end
      tick();
   endtask

   task automatic test_zero();
      int cyc;
      run_op(32'h12345678, 32'h12345678, 1'b0, cyc);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL zero_d got %h want 00000000", d); end
      checks++; if (zero !== 1'b1 || bout !== 1'b0) begin errors++; $display("FAIL zero_flags got zero=%b bout=%b want 1 0", zero, bout); end
      tick();
      run_op(32'h12345678, 32'h12345678, 1'b1, cyc);
      checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL zero_bin_d got %h want ffffffff", d); end
      checks++; if (zero !== 1'b0 || bout !== 1'b1) begin errors++; $display("FAIL zero_bin_flags got zero=%b bout=%b want 0 1", zero, bout); end
      tick();
   endtask

   task automatic test_ovf();
      int cyc;
      run_op(32'h80000000, 32'h00000001, 1'b0, cyc);
      checks++; if (d !== 32'h7FFFFFFF || bout !== 1'b0) begin errors++; $display("FAIL ovf_neg_d got d=%h bout=%b want 7fffffff 0", d, bout); end
`ifdef SUB_OVF_EN
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_neg got %b want 1", ovf); end
`endif
      tick();
      run_op(32'h00000100, 32'h00000001, 1'b0, cyc);
      checks++; if (d !== 32'h000000FF || bout !== 1'b0) begin errors++; $display("FAIL ovf_none_d got d=%h bout=%b want 000000ff 0", d, bout); end
`ifdef SUB_OVF_EN
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_none got %b want 0", ovf); end
`endif
      tick();
      run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, cyc);
      checks++; if (d !== 32'h80000000 || bout !== 1'b1) begin errors++; $display("FAIL ovf_pos_d got d=%h bout=%b want 80000000 1", d, bout); end
`ifdef SUB_OVF_EN
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_pos got %b want 1", ovf); end
`endif
      tick();
   endtask

   task automatic test_backpressure();
      int cyc;
      out_ready = 1'b0;
      run_op(32'd10, 32'd4, 1'b0, cyc);
      checks++; if (cyc !== 4 || d !== 32'd6) begin errors++; $display("FAIL bp_result got cyc=%0d d=%h want 4 00000006", cyc, d); end
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         a        = 32'd99 + 32'(i);
         b        = 32'd1;
         tick();
         checks++;
         if (out_valid !== 1'b1 || d !== 32'd6 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d] got out_valid=%b d=%h in_ready=%b want 1 00000006 0", i, out_valid, d, in_ready);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
      checks++; if (d !== 32'd6) begin errors++; $display("FAIL bp_d_after got %h want 00000006", d); end
      tick();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_ghost got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
   endtask

   task automatic test_reset_mid();
      int cyc;
      a        = 32'h00000007;
      b        = 32'h00000002;
      bin      = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ctrl got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrst_d got %h want 00000000", d); end
      for (int i = 0; i < 5; i++) tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_aborted got out_valid=%b want 0", out_valid); end
      run_op(32'h00001000, 32'h00000001, 1'b0, cyc);
      checks++; if (cyc !== 4) begin errors++; $display("FAIL midrst_fresh_latency got %0d want 4", cyc); end
      checks++; if (d !== 32'h00000FFF || bout !== 1'b0 || zero !== 1'b0) begin errors++; $display("FAIL midrst_fresh got d=%h bout=%b zero=%b want 00000fff 0 0", d, bout, zero); end
      tick();
   endtask

   task automatic test_back_to_back();
      int cyc;
      run_op(32'h00010000, 32'h00000001, 1'b1, cyc);
      checks++; if (d !== 32'h0000FFFE || bout !== 1'b0) begin errors++; $display("FAIL b2b_first got d=%h bout=%b want 0000fffe 0", d, bout); end
      a        = 32'hFFFFFFFF;
      b        = 32'hFFFFFFFF;
      bin      = 1'b0;
      in_valid = 1'b1;
      tick();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_turnaround got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, cyc);
      checks++; if (cyc !== 4 || d !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL b2b_second got cyc=%0d d=%h zero=%b want 4 00000000 1", cyc, d, zero); end
      tick();
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      bin       = 1'b0;
      test_reset();
      test_basic();
      test_borrow_ripple();
      test_zero();
      test_ovf();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
